// File: rtl/smem_hsi_pkg.sv
// Shared SMEM header/segment interface definitions, used by both reader and writer.
// Latency: n/a (types, constants and a sizing helper only).
// Backpressure: n/a.
package smem_hsi_pkg;

  localparam int SEGMENTS            = 4;
  localparam int DEFAULT_DW          = 512;
  localparam int ENTRIES_PER_SEGMENT = DEFAULT_DW / 32;

  // Entries per segment for a non-default segment width.
  function automatic int entries_per_segment(input int dw);
    return dw / 32;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_ORPHAN    = 2'd1,
    ERR_EARLY_HDR = 2'd2,
    ERR_TLAST     = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/smem_reader_hsi_s1_if.sv
// Bundle of stream-in, row-out and error signals of the SMEM reader.
// Latency: n/a (wiring only).
// Backpressure: axis_in_tready toward the stream source, row_ready from the row consumer.
// Ports: axis_in_* = 32-bit header/entry stream; smem_data*/row_index/row_valid/row_ready =
// reassembled row handshake; err_strobe/err_code = protocol error report.
// slave = reader view, master = stream source / row consumer view.
interface smem_reader_hsi_s1_if #(parameter int DW = 512);
  logic [31:0]   axis_in_tdata;
  logic          axis_in_tuser;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [DW-1:0] smem_data3;
  logic [DW-1:0] smem_data2;
  logic [DW-1:0] smem_data1;
  logic [DW-1:0] smem_data0;
  logic [31:0]   row_index;
  logic          row_valid;
  logic          row_ready;
  logic          err_strobe;
  logic [1:0]    err_code;

  modport slave (
    input  axis_in_tdata, axis_in_tuser, axis_in_tlast, axis_in_tvalid, row_ready,
    output axis_in_tready, smem_data3, smem_data2, smem_data1, smem_data0,
           row_index, row_valid, err_strobe, err_code
  );

  modport master (
    output axis_in_tdata, axis_in_tuser, axis_in_tlast, axis_in_tvalid, row_ready,
    input  axis_in_tready, smem_data3, smem_data2, smem_data1, smem_data0,
           row_index, row_valid, err_strobe, err_code
  );
endinterface

// File: rtl/smem_reader_hsi_s1.sv
// Rebuilds a 4-segment SMEM row from a header beat followed by 32-bit entry beats.
// Latency: row_valid rises the cycle after the last entry is accepted.
// Backpressure: tready drops while a completed row waits for row_ready (and in reset).
// Ports: clk, resetn (synchronous, active-low), bus = smem_reader_hsi_s1_if.slave.
module smem_reader_hsi_s1
  import smem_hsi_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  smem_reader_hsi_s1_if.slave  bus
);

  localparam int EPS     = entries_per_segment(DW);
  localparam int ENTRIES = SEGMENTS * EPS;
  localparam int CW      = $clog2(ENTRIES);
  localparam logic [CW-1:0] LAST = CW'(ENTRIES - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [31:0]              row_index_q;
  logic [SEGMENTS*DW-1:0]   row_q;
  logic                     err_strobe_q;
  err_code_t                err_code_q;

  logic                     accept;
  logic                     load_hdr;
  logic                     wr_en;
  logic                     err_set;
  err_code_t                err_new;
  logic [ENTRIES-1:0]       entry_en;

  // tready is gated by resetn directly so nothing is accepted during reset.
  assign bus.axis_in_tready = resetn && (state_q != ST_FULL);
  assign accept             = bus.axis_in_tvalid && bus.axis_in_tready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_hdr = 1'b0;
    wr_en    = 1'b0;
    err_set  = 1'b0;
    err_new  = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.axis_in_tuser) begin
            load_hdr = 1'b1;
            cnt_d    = '0;
            state_d  = ST_DATA;
          end else begin
            err_set = 1'b1;
            err_new = ERR_ORPHAN;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (bus.axis_in_tuser) begin
            // New header restarts the row; stale entries get overwritten.
            err_set  = 1'b1;
            err_new  = ERR_EARLY_HDR;
            load_hdr = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == LAST) begin
            // Counter parks at LAST; it is only cleared by the next header.
            wr_en   = 1'b1;
            state_d = ST_FULL;
            if (!bus.axis_in_tlast) begin
              err_set = 1'b1;
              err_new = ERR_TLAST;
            end
          end else if (bus.axis_in_tlast) begin
            // Short row: drop it, the terminating beat is not stored.
            err_set = 1'b1;
            err_new = ERR_TLAST;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (bus.row_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One write enable per entry slot, decoded from the counter.
  always_comb begin
    entry_en = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_en && (cnt_q == CW'(i))) entry_en[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      row_index_q  <= '0;
      row_q        <= '0;
      err_strobe_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_strobe_q <= err_set;
      if (err_set)  err_code_q  <= err_new;
      if (load_hdr) row_index_q <= bus.axis_in_tdata;
      // Entry k lands in segment k/EPS at bit offset (k mod EPS)*32, i.e. flat offset k*32.
      for (int i = 0; i < ENTRIES; i++) begin
        if (entry_en[i]) row_q[i*32 +: 32] <= bus.axis_in_tdata;
      end
    end
  end

  assign bus.smem_data0 = row_q[0*DW +: DW];
  assign bus.smem_data1 = row_q[1*DW +: DW];
  assign bus.smem_data2 = row_q[2*DW +: DW];
  assign bus.smem_data3 = row_q[3*DW +: DW];
  assign bus.row_index  = row_index_q;
  assign bus.row_valid  = (state_q == ST_FULL);
  assign bus.err_strobe = err_strobe_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_smem_reader_hsi_s1.sv
// Scenario bench for smem_reader_hsi_s1: scoreboarded rows plus inline per-scenario checks.
// Latency: n/a (testbench).
// Backpressure: drives row_ready low in the hold scenario.
module tb_smem_reader_hsi_s1;

  localparam int DW  = 512;
  localparam int EPS = DW / 32;
  localparam int ENT = 4 * EPS;

  typedef struct packed {
    logic [31:0]            idx;
    logic [3:0][DW-1:0]     seg;
  } row_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  smem_reader_hsi_s1_if #(.DW(DW)) bus ();
  smem_reader_hsi_s1 #(.DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  row_t exp_q[$];
  row_t rcv_q[$];
  row_t mon_r;
  int   errors = 0;
  int   checks = 0;
  int   err_pulses = 0;

  // Capture every row handed over (row_valid & row_ready at a rising edge).
  always @(posedge clk) begin
    if (resetn && bus.row_valid && bus.row_ready) begin
      mon_r.idx = bus.row_index;
      mon_r.seg = {bus.smem_data3, bus.smem_data2, bus.smem_data1, bus.smem_data0};
      rcv_q.push_back(mon_r);
    end
    if (resetn && bus.err_strobe) err_pulses++;
  end

  function automatic row_t make_row(input logic [31:0] idx, input logic [31:0] base);
    row_t r;
    r.idx = idx;
    r.seg = '0;
    for (int k = 0; k < ENT; k++) r.seg[k / EPS][(k % EPS) * 32 +: 32] = base + 32'(k);
    return r;
  endfunction

  // Present one beat from a falling edge and hold it until it has been accepted.
  task automatic send(input logic [31:0] d, input logic u, input logic l);
    int n = 0;
    bus.axis_in_tdata  = d;
    bus.axis_in_tuser  = u;
    bus.axis_in_tlast  = l;
    bus.axis_in_tvalid = 1'b1;
    while (!bus.axis_in_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout got tready=%b want 1 within 100 cycles", bus.axis_in_tready);
    end
    @(negedge clk);
    bus.axis_in_tvalid = 1'b0;
  endtask

  // Entries first..first+n-1 of base; the last one carries tlast=l_end.
  task automatic send_entries(input logic [31:0] base, input int first, input int n, input logic l_end);
    for (int k = first; k < first + n; k++)
      send(base + 32'(k), 1'b0, (k == first + n - 1) ? l_end : 1'b0);
  endtask

  task automatic wait_rows(input int want);
    int n = 0;
    while (rcv_q.size() < want && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.axis_in_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b want=0", bus.axis_in_tready); end
    checks++; if (bus.row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid got=%b want=0", bus.row_valid); end
    checks++; if (bus.err_strobe !== 1'b0 || bus.err_code !== 2'd0) begin errors++; $display("FAIL reset_err got=%b/%0d want=0/0", bus.err_strobe, bus.err_code); end
    checks++; if (bus.row_index !== 32'h0 || {bus.smem_data3, bus.smem_data2, bus.smem_data1, bus.smem_data0} !== '0) begin
      errors++; $display("FAIL reset_data got idx=%h d0=%h want zero", bus.row_index, bus.smem_data0[31:0]); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (bus.axis_in_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got=%b want=1", bus.axis_in_tready); end
  endtask

  task automatic test_basic_row;
    row_t got_r, exp_r;
    int e0 = err_pulses;
    exp_q.push_back(make_row(32'h123, 32'hA000_0000));
    send(32'h0000_0123, 1'b1, 1'b0);
    send_entries(32'hA000_0000, 0, ENT, 1'b1);
    checks++; if (bus.row_valid !== 1'b1) begin errors++; $display("FAIL basic_row_valid got=%b want=1", bus.row_valid); end
    checks++; if (bus.row_index !== 32'h123) begin errors++; $display("FAIL basic_row_index got=%h want=123", bus.row_index); end
    checks++; if (bus.smem_data0[31:0] !== 32'hA000_0000) begin errors++; $display("FAIL basic_d0 got=%h want=a0000000", bus.smem_data0[31:0]); end
    checks++; if (bus.smem_data3[511:480] !== 32'hA000_003F) begin errors++; $display("FAIL basic_d3 got=%h want=a000003f", bus.smem_data3[511:480]); end
    wait_rows(1);
    checks++;
    if (rcv_q.size() == 0) begin errors++; $display("FAIL basic_sb got=no row want=row 123"); void'(exp_q.pop_front()); end
    else begin
      got_r = rcv_q.pop_front(); exp_r = exp_q.pop_front();
      if (got_r !== exp_r) begin errors++; $display("FAIL basic_sb got idx=%h d0=%h want idx=%h d0=%h", got_r.idx, got_r.seg[0][31:0], exp_r.idx, exp_r.seg[0][31:0]); end
    end
    @(negedge clk);
    checks++; if (bus.row_valid !== 1'b0 || err_pulses != e0) begin errors++; $display("FAIL basic_after got valid=%b errs=%0d want 0/0", bus.row_valid, err_pulses - e0); end
  endtask

  task automatic test_back_pressure;
    row_t got_r, exp_r;
    bit stable = 1'b1;
    bus.row_ready = 1'b0;
    exp_q.push_back(make_row(32'h200, 32'hB000_0000));
    send(32'h200, 1'b1, 1'b0);
    send_entries(32'hB000_0000, 0, ENT, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (bus.axis_in_tready !== 1'b0 || bus.row_valid !== 1'b1 || bus.row_index !== 32'h200 ||
          bus.smem_data0[31:0] !== 32'hB000_0000 || bus.smem_data3[511:480] !== 32'hB000_003F) stable = 1'b0;
      @(negedge clk);
    end
    checks++; if (!stable) begin errors++; $display("FAIL hold_stable got tready=%b valid=%b idx=%h want 0/1/200", bus.axis_in_tready, bus.row_valid, bus.row_index); end
    bus.axis_in_tdata = 32'h201; bus.axis_in_tuser = 1'b1; bus.axis_in_tlast = 1'b0; bus.axis_in_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.axis_in_tready !== 1'b0 || bus.row_index !== 32'h200) begin errors++; $display("FAIL hold_hdr_wait got tready=%b idx=%h want 0/200", bus.axis_in_tready, bus.row_index); end
    bus.row_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.axis_in_tready !== 1'b1 || bus.row_valid !== 1'b0) begin errors++; $display("FAIL release got tready=%b valid=%b want 1/0", bus.axis_in_tready, bus.row_valid); end
    @(negedge clk);
    bus.axis_in_tvalid = 1'b0;
    exp_q.push_back(make_row(32'h201, 32'hC000_0000));
    send_entries(32'hC000_0000, 0, ENT, 1'b1);
    wait_rows(2);
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (rcv_q.size() == 0) begin errors++; $display("FAIL hold_sb%0d got=no row want=row", r); void'(exp_q.pop_front()); end
      else begin
        got_r = rcv_q.pop_front(); exp_r = exp_q.pop_front();
        if (got_r !== exp_r) begin errors++; $display("FAIL hold_sb%0d got idx=%h d0=%h want idx=%h d0=%h", r, got_r.idx, got_r.seg[0][31:0], exp_r.idx, exp_r.seg[0][31:0]); end
      end
    end
  endtask

  task automatic test_orphan;
    row_t got_r, exp_r;
    int e0 = err_pulses;
    send(32'h5555_5555, 1'b0, 1'b0);
    checks++; if (bus.err_strobe !== 1'b1 || bus.err_code !== 2'd1) begin errors++; $display("FAIL orphan_err got=%b/%0d want=1/1", bus.err_strobe, bus.err_code); end
    checks++; if (bus.row_valid !== 1'b0 || bus.axis_in_tready !== 1'b1) begin errors++; $display("FAIL orphan_state got valid=%b tready=%b want 0/1", bus.row_valid, bus.axis_in_tready); end
    @(negedge clk);
    checks++; if (bus.err_strobe !== 1'b0 || err_pulses - e0 != 1) begin errors++; $display("FAIL orphan_pulse got strobe=%b pulses=%0d want 0/1", bus.err_strobe, err_pulses - e0); end
    checks++; if (rcv_q.size() != 0) begin errors++; $display("FAIL orphan_norow got=%0d rows want=0", rcv_q.size()); end
    exp_q.push_back(make_row(32'h300, 32'h3000_0000));
    send(32'h300, 1'b1, 1'b0);
    send_entries(32'h3000_0000, 0, ENT, 1'b1);
    wait_rows(1);
    checks++;
    if (rcv_q.size() == 0) begin errors++; $display("FAIL orphan_sb got=no row want=row 300"); void'(exp_q.pop_front()); end
    else begin
      got_r = rcv_q.pop_front(); exp_r = exp_q.pop_front();
      if (got_r !== exp_r) begin errors++; $display("FAIL orphan_sb got idx=%h d0=%h want idx=%h d0=%h", got_r.idx, got_r.seg[0][31:0], exp_r.idx, exp_r.seg[0][31:0]); end
    end
  endtask

  task automatic test_early_header;
    row_t got_r, exp_r;
    send(32'h10, 1'b1, 1'b0);
    send_entries(32'hC100_0000, 0, 20, 1'b0);
    send(32'h11, 1'b1, 1'b0);
    checks++; if (bus.err_strobe !== 1'b1 || bus.err_code !== 2'd2 || bus.row_index !== 32'h11) begin
      errors++; $display("FAIL early_hdr got=%b/%0d idx=%h want=1/2 idx=11", bus.err_strobe, bus.err_code, bus.row_index); end
    exp_q.push_back(make_row(32'h11, 32'hD000_0000));
    send_entries(32'hD000_0000, 0, ENT, 1'b1);
    wait_rows(1);
    checks++;
    if (rcv_q.size() == 0) begin errors++; $display("FAIL early_sb got=no row want=row 11"); void'(exp_q.pop_front()); end
    else begin
      got_r = rcv_q.pop_front(); exp_r = exp_q.pop_front();
      if (got_r !== exp_r) begin errors++; $display("FAIL early_sb got idx=%h d0=%h want idx=%h d0=%h", got_r.idx, got_r.seg[0][31:0], exp_r.idx, exp_r.seg[0][31:0]); end
    end
  endtask

  task automatic test_tlast;
    row_t got_r, exp_r;
    send(32'h400, 1'b1, 1'b0);
    send_entries(32'hE100_0000, 0, 31, 1'b1);
    checks++; if (bus.err_strobe !== 1'b1 || bus.err_code !== 2'd3) begin errors++; $display("FAIL tlast_short_err got=%b/%0d want=1/3", bus.err_strobe, bus.err_code); end
    checks++; if (bus.row_valid !== 1'b0 || bus.axis_in_tready !== 1'b1) begin errors++; $display("FAIL tlast_short_state got valid=%b tready=%b want 0/1", bus.row_valid, bus.axis_in_tready); end
    repeat (3) @(negedge clk);
    checks++; if (rcv_q.size() != 0) begin errors++; $display("FAIL tlast_short_norow got=%0d rows want=0", rcv_q.size()); end
    exp_q.push_back(make_row(32'h401, 32'hE000_0000));
    send(32'h401, 1'b1, 1'b0);
    send_entries(32'hE000_0000, 0, ENT, 1'b0);
    checks++; if (bus.row_valid !== 1'b1 || bus.err_strobe !== 1'b1 || bus.err_code !== 2'd3) begin
      errors++; $display("FAIL tlast_missing got valid=%b err=%b/%0d want 1 1/3", bus.row_valid, bus.err_strobe, bus.err_code); end
    wait_rows(1);
    checks++;
    if (rcv_q.size() == 0) begin errors++; $display("FAIL tlast_sb got=no row want=row 401"); void'(exp_q.pop_front()); end
    else begin
      got_r = rcv_q.pop_front(); exp_r = exp_q.pop_front();
      if (got_r !== exp_r) begin errors++; $display("FAIL tlast_sb got idx=%h d0=%h want idx=%h d0=%h", got_r.idx, got_r.seg[0][31:0], exp_r.idx, exp_r.seg[0][31:0]); end
    end
  endtask

  task automatic test_reset_mid_row;
    row_t got_r, exp_r;
    int e0;
    send(32'h500, 1'b1, 1'b0);
    send_entries(32'hF000_0000, 0, 41, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (bus.axis_in_tready !== 1'b0 || bus.row_valid !== 1'b0 || bus.err_strobe !== 1'b0 || bus.err_code !== 2'd0) begin
      errors++; $display("FAIL midreset_ctl got tready=%b valid=%b err=%b/%0d want all 0", bus.axis_in_tready, bus.row_valid, bus.err_strobe, bus.err_code); end
    checks++; if (bus.row_index !== 32'h0 || {bus.smem_data3, bus.smem_data2, bus.smem_data1, bus.smem_data0} !== '0) begin
      errors++; $display("FAIL midreset_data got idx=%h d0=%h want zero", bus.row_index, bus.smem_data0[31:0]); end
    resetn = 1'b1;
    @(negedge clk);
    e0 = err_pulses;
    exp_q.push_back(make_row(32'h501, 32'h7000_0000));
    send(32'h501, 1'b1, 1'b0);
    send_entries(32'h7000_0000, 0, ENT, 1'b1);
    wait_rows(1);
    checks++;
    if (rcv_q.size() == 0) begin errors++; $display("FAIL midreset_sb got=no row want=row 501"); void'(exp_q.pop_front()); end
    else begin
      got_r = rcv_q.pop_front(); exp_r = exp_q.pop_front();
      if (got_r !== exp_r) begin errors++; $display("FAIL midreset_sb got idx=%h d0=%h want idx=%h d0=%h", got_r.idx, got_r.seg[0][31:0], exp_r.idx, exp_r.seg[0][31:0]); end
    end
    checks++; if (bus.err_code !== 2'd0 || err_pulses != e0) begin errors++; $display("FAIL midreset_noerr got code=%0d pulses=%0d want 0/0", bus.err_code, err_pulses - e0); end
  endtask

  initial begin
    bus.axis_in_tdata  = '0;
    bus.axis_in_tuser  = 1'b0;
    bus.axis_in_tlast  = 1'b0;
    bus.axis_in_tvalid = 1'b0;
    bus.row_ready      = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_row();
    test_back_pressure();
    test_orphan();
    test_early_header();
    test_tlast();
    test_reset_mid_row();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
